// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and helpers for the load/store unit
package lsu_pkg;
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, DONE} state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] sz);
        return sz[1] ? 3'd4 : sz[0] ? 3'd2 : 3'd1;
    endfunction
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: extracts/extends load data and merges sub-word store data into a word
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  a,
    input  logic [2:0]  size,
    input  logic [31:0] wd,
    output logic [31:0] ld_val,
    output logic [31:0] st_word
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = word[{a, 3'b000} +: 8];
    assign h = a[1] ? word[31:16] : word[15:0];

    // load value: pick the addressed lane, then sign- or zero-extend
    always_comb begin
        ld_val = size == SZ_W  ? word :
                 size == SZ_B  ? {{24{b[7]}}, b} :
                 size == SZ_H  ? {{16{h[15]}}, h} :
                 size == SZ_BU ? {24'b0, b} : {16'b0, h};
    end

    // store word: full word replaces everything, sub-words replace only their lane
    always_comb begin
        st_word = word;
        if (size[1])
            st_word = wd;
        else if (size[0])
            st_word[{a[1], 4'b0000} +: 16] = wd[15:0];
        else
            st_word[{a, 3'b000} +: 8] = wd[7:0];
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns core byte/half/word loads and stores into aligned word accesses
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_size,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wd,
    output logic [31:0] core_rd,
    output logic        core_stall,
    output logic        core_fault,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    state_t      state, state_n;
    logic [2:0]  size_q;
    logic [1:0]  a_q;
    logic [31:0] wd_q, rmw_word, ld_val, st_word;
    logic        legal, mis, range_err, fault;

    lsu_byte_lane u_lane (
        .word    (state == LOAD ? mem_rd : rmw_word),
        .a       (a_q),
        .size    (size_q),
        .wd      (wd_q),
        .ld_val  (ld_val),
        .st_word (st_word)
    );

    // classify the incoming request; the sum is 33 bits so addresses near 2^32 cannot wrap
    always_comb begin
        legal     = core_size inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
        mis       = (core_size[1:0] == 2'b01 && core_addr[0]) ||
                    (core_size[1:0] == 2'b10 && core_addr[1:0] != 2'b00);
        range_err = {1'b0, core_addr} + 33'(size_bytes(core_size)) > 33'(MEM_BYTES);
        fault     = !legal || mis || range_err;
    end

    // next-state logic and memory-side strobes
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (core_req)
                         state_n = fault ? DONE :
                                   !core_we ? LOAD :
                                   core_size[1:0] == 2'b10 ? STORE_W : RMW_RD;
            LOAD:    state_n = DONE;
            STORE_W: state_n = DONE;
            RMW_RD:  state_n = RMW_WR;
            RMW_WR:  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        core_stall = core_req && state != DONE;
        mem_we     = state == STORE_W || state == RMW_WR;
        mem_wd     = mem_we ? st_word : 32'b0;
    end

    // request latch, aligned address, load result and read-modify-write capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            size_q     <= '0;
            a_q        <= '0;
            wd_q       <= '0;
            rmw_word   <= '0;
            mem_addr   <= '0;
            core_rd    <= '0;
            core_fault <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && core_req) begin
                size_q     <= core_size;
                a_q        <= core_addr[1:0];
                wd_q       <= core_wd;
                mem_addr   <= {core_addr[31:2], 2'b00};
                core_fault <= fault;
            end
            if (state == LOAD)
                core_rd <= ld_val;
            if (state == RMW_RD)
                rmw_word <= mem_rd;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit against a byte RAM model
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 0, rst = 1;
    logic        core_req = 0, core_we = 0;
    logic [2:0]  core_size = 0;
    logic [31:0] core_addr = 0, core_wd = 0;
    logic [31:0] core_rd, mem_addr, mem_wd, mem_rd;
    logic        core_stall, core_fault, mem_we;
    logic        pl_en = 0;
    logic [9:0]  pl_addr = 0;
    logic [31:0] pl_data = 0;
    logic [7:0]  ram [0:1023];
    int          total = 0, bad = 0;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst), .core_req(core_req), .core_we(core_we),
        .core_size(core_size), .core_addr(core_addr), .core_wd(core_wd),
        .core_rd(core_rd), .core_stall(core_stall), .core_fault(core_fault),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = {ram[{mem_addr[9:2], 2'd3}], ram[{mem_addr[9:2], 2'd2}],
                     ram[{mem_addr[9:2], 2'd1}], ram[{mem_addr[9:2], 2'd0}]};

    always @(posedge clk) begin
        if (pl_en)
            {ram[{pl_addr[9:2], 2'd3}], ram[{pl_addr[9:2], 2'd2}],
             ram[{pl_addr[9:2], 2'd1}], ram[{pl_addr[9:2], 2'd0}]} <= pl_data;
        else if (mem_we)
            {ram[{mem_addr[9:2], 2'd3}], ram[{mem_addr[9:2], 2'd2}],
             ram[{mem_addr[9:2], 2'd1}], ram[{mem_addr[9:2], 2'd0}]} <= mem_wd;
    end

    function automatic logic [31:0] ram_word(input logic [9:0] a);
        return {ram[{a[9:2], 2'd3}], ram[{a[9:2], 2'd2}], ram[{a[9:2], 2'd1}], ram[{a[9:2], 2'd0}]};
    endfunction

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pl_en = 1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 0;
    endtask

    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a, wd,
                          input bit bb, input bit drop,
                          output int stalls, output int wes, output logic [31:0] rd, output logic flt);
        core_req = 1; core_we = we; core_size = sz; core_addr = a; core_wd = wd;
        stalls = 0; wes = 0;
        if (bb) begin @(posedge clk); #1; end
        else #1;
        for (int i = 0; i < 10 && core_stall; i++) begin
            stalls++;
            if (mem_we) wes++;
            @(posedge clk); #1;
        end
        total++;
        if (core_stall) begin
            bad++;
            $display("FAIL timeout addr=%h still stalled after %0d cycles", a, stalls);
        end
        rd = core_rd; flt = core_fault;
        if (mem_we) wes++;
        if (drop) begin
            core_req = 0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        total++;
        if (core_rd !== 0 || core_fault !== 0 || mem_we !== 0 || mem_wd !== 0 || mem_addr !== 0 || core_stall !== 0) begin
            bad++;
            $display("FAIL reset rd=%h fault=%b we=%b wd=%h addr=%h stall=%b expected all 0",
                     core_rd, core_fault, mem_we, mem_wd, mem_addr, core_stall);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  szs [4] = '{SZ_B, SZ_BU, SZ_H, SZ_HU};
        logic [31:0] adr [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        int s, w; logic [31:0] rd; logic f;
        for (int i = 0; i < 4; i++) begin
            access(0, szs[i], adr[i], 0, 0, 0, s, w, rd, f);
            total++;
            if (mem_addr !== 32'h10) begin
                bad++;
                $display("FAIL load_addr[%0d] got=%h want=%h", i, mem_addr, 32'h10);
            end
            core_req = 0; @(posedge clk); #1;
            total++;
            if (rd !== exp[i] || s != 2 || w != 0 || f !== 0) begin
                bad++;
                $display("FAIL load[%0d] rd=%h stalls=%0d we=%0d fault=%b want rd=%h stalls=2 we=0 fault=0",
                         i, rd, s, w, f, exp[i]);
            end
        end
    endtask

    task automatic test_store_word();
        int s, w; logic [31:0] rd; logic f;
        access(1, SZ_W, 32'h20, 32'hDEADBEEF, 0, 1, s, w, rd, f);
        total++;
        if (ram_word(10'h20) !== 32'hDEADBEEF || s != 2 || w != 1 || f !== 0) begin
            bad++;
            $display("FAIL sw word=%h stalls=%0d we=%0d fault=%b want DEADBEEF 2 1 0", ram_word(10'h20), s, w, f);
        end
        access(0, SZ_W, 32'h20, 0, 0, 1, s, w, rd, f);
        total++;
        if (rd !== 32'hDEADBEEF || s != 2) begin
            bad++;
            $display("FAIL lw rd=%h stalls=%0d want DEADBEEF 2", rd, s);
        end
    endtask

    task automatic test_rmw();
        int s, w; logic [31:0] rd; logic f;
        access(1, SZ_B, 32'h21, 32'h12345655, 0, 1, s, w, rd, f);
        total++;
        if (ram_word(10'h20) !== 32'hDEAD55EF || s != 3 || w != 1) begin
            bad++;
            $display("FAIL sb word=%h stalls=%0d we=%0d want DEAD55EF 3 1", ram_word(10'h20), s, w);
        end
        access(1, SZ_H, 32'h22, 32'hAAAA1234, 0, 1, s, w, rd, f);
        total++;
        if (ram_word(10'h20) !== 32'h123455EF || s != 3 || w != 1) begin
            bad++;
            $display("FAIL sh word=%h stalls=%0d we=%0d want 123455EF 3 1", ram_word(10'h20), s, w);
        end
    endtask

    task automatic test_faults();
        logic        wes_ [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  szs [4] = '{SZ_H, SZ_W, SZ_W, 3'b011};
        logic [31:0] adr [4] = '{32'h11, 32'h22, 32'h3FE, 32'h20};
        int s, w; logic [31:0] rd; logic f;
        for (int i = 0; i < 4; i++) begin
            access(wes_[i], szs[i], adr[i], 32'h5A5A5A5A, 0, 1, s, w, rd, f);
            total++;
            if (f !== 1 || s != 1 || w != 0) begin
                bad++;
                $display("FAIL fault[%0d] fault=%b stalls=%0d we=%0d want 1 1 0", i, f, s, w);
            end
        end
        total++;
        if (ram_word(10'h20) !== 32'h123455EF || ram_word(10'h3FC) !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL fault_ram w20=%h w3fc=%h want 123455EF CAFEF00D", ram_word(10'h20), ram_word(10'h3FC));
        end
        access(0, SZ_W, 32'h3FC, 0, 0, 1, s, w, rd, f);
        total++;
        if (f !== 0 || rd !== 32'hCAFEF00D || s != 2) begin
            bad++;
            $display("FAIL edge_lw fault=%b rd=%h stalls=%0d want 0 CAFEF00D 2", f, rd, s);
        end
    endtask

    task automatic test_reset_mid();
        int s, w, we_seen; logic [31:0] rd; logic f;
        we_seen = 0;
        core_req = 1; core_we = 1; core_size = SZ_B; core_addr = 32'h30; core_wd = 32'h99;
        @(posedge clk); #1;
        rst = 1; core_req = 0;
        if (mem_we) we_seen++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (mem_we) we_seen++;
        end
        rst = 0;
        @(posedge clk); #1;
        total++;
        if (we_seen != 0 || ram_word(10'h30) !== 32'h11223344 || core_stall !== 0) begin
            bad++;
            $display("FAIL reset_mid we=%0d word=%h stall=%b want 0 11223344 0", we_seen, ram_word(10'h30), core_stall);
        end
        access(0, SZ_W, 32'h30, 0, 0, 1, s, w, rd, f);
        total++;
        if (rd !== 32'h11223344 || s != 2 || f !== 0) begin
            bad++;
            $display("FAIL reset_mid_lw rd=%h stalls=%0d fault=%b want 11223344 2 0", rd, s, f);
        end
    endtask

    task automatic test_back_to_back();
        int s, w; logic [31:0] rd; logic f;
        access(1, SZ_B, 32'h40, 32'hA5, 0, 0, s, w, rd, f);
        total++;
        if (s != 3 || w != 1 || ram_word(10'h40) !== 32'h112233A5) begin
            bad++;
            $display("FAIL b2b_sb stalls=%0d we=%0d word=%h want 3 1 112233A5", s, w, ram_word(10'h40));
        end
        access(0, SZ_BU, 32'h40, 0, 1, 1, s, w, rd, f);
        total++;
        if (rd !== 32'h000000A5 || s != 2 || w != 0) begin
            bad++;
            $display("FAIL b2b_lbu rd=%h stalls=%0d we=%0d want 000000A5 2 0", rd, s, w);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        preload(10'h10, 32'h80FF7F01);
        preload(10'h20, 32'h0);
        preload(10'h30, 32'h11223344);
        preload(10'h40, 32'h11223344);
        preload(10'h3FC, 32'hCAFEF00D);
        test_reset();
        rst = 0;
        @(posedge clk); #1;
        test_loads();
        test_store_word();
        test_rmw();
        test_faults();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
